turn_executor: RTL and testbench
================================

TURN_EXECUTOR -- requirements
Module: turn_executor

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 450, meaning clk cycles of rotation for one 90-degree turn (0.9 s at 500 Hz), legal range 1..32767.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 50, meaning clk cycles of stationary hold after rotation so the detectors refresh, legal range 1..65535.
REQ-003 SHALL have port clk  input  1  system clock, 500 Hz.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  semi-auto mode active.
REQ-006 SHALL have port trigger_turn_left  input  1  request a 90-degree left turn.
REQ-007 SHALL have port trigger_turn_right  input  1  request a 90-degree right turn.
REQ-008 SHALL have port trigger_turn_back  input  1  request a 180-degree turn.
REQ-009 SHALL have port is_turning  output  1  turn in progress; returned to the turn requester.
REQ-010 SHALL have port rotate_left  output  1  drive wheels counter-clockwise.
REQ-011 SHALL have port rotate_right  output  1  drive wheels clockwise.
REQ-012 SHALL have port turn_done  output  1  one-cycle pulse when a turn completes.

Function
REQ-013 SHALL implement states IDLE, ROTATE and SETTLE, and SHALL register all outputs.
REQ-014 IDLE: is_turning=0, rotate_left=0, rotate_right=0; triggers are sampled on each rising clk edge while enable=1.
REQ-015 When a trigger is sampled at edge k, the block SHALL enter ROTATE at edge k, and is_turning plus the selected rotate output SHALL be 1 in the cycle after edge k (one-cycle latency).
REQ-016 Simultaneous triggers SHALL resolve with priority back > left > right, and only one turn SHALL execute.
REQ-017 Left turns SHALL assert rotate_left for exactly TURN_CYCLES cycles; right turns SHALL assert rotate_right for exactly TURN_CYCLES cycles.
REQ-018 Back turns SHALL assert rotate_left for exactly 2*TURN_CYCLES cycles; the cycle counter SHALL be 16 bits, and no wrap is possible within the legal parameter range.
REQ-019 rotate_left and rotate_right SHALL never both be 1.
REQ-020 After ROTATE, the block SHALL enter SETTLE for exactly SETTLE_CYCLES cycles, with is_turning=1 and both rotate outputs 0.
REQ-021 At SETTLE end, the block SHALL return to IDLE; in that first IDLE cycle is_turning=0 and turn_done=1, and turn_done SHALL be 0 in all other cycles.
REQ-022 Triggers arriving in ROTATE or SETTLE SHALL be ignored and not queued.
REQ-023 A trigger held high through completion SHALL start a new turn on the first IDLE edge, because triggers are level-sampled.
REQ-024 If enable=0 is sampled in any state, the block SHALL go to IDLE on that edge, with all outputs 0 and no turn_done pulse.
REQ-025 In IDLE, triggers SHALL be ignored while enable=0.

Reset
REQ-026 rst_n=0 SHALL immediately force state to IDLE, clear the counter and direction register, and drive all outputs to 0, independent of clk.
REQ-027 Reset asserted mid-turn SHALL abort the turn with no turn_done pulse; after release the block SHALL start a turn only on a fresh sampled trigger.

Verification (TURN_CYCLES=4, SETTLE_CYCLES=2)
REQ-028 Left turn: enable=1, trigger_turn_left pulsed for 1 cycle -> rotate_left=1 for 4 cycles, then is_turning=1 with rotate outputs 0 for 2 cycles, then turn_done=1 for 1 cycle; is_turning=1 for 6 cycles total.
REQ-029 Back turn: trigger_turn_back pulsed -> rotate_left=1 for 8 cycles, rotate_right stays 0, is_turning=1 for 10 cycles, then one turn_done pulse.
REQ-030 Priority and blocking: left and right pulsed together -> only rotate_left active; trigger_turn_right pulsed during ROTATE -> ignored, and no second turn follows.
REQ-031 Disable mid-turn: enable dropped on the 2nd rotation cycle -> all outputs 0 on the next edge, turn_done never asserts, and triggers are ignored while enable=0.
REQ-032 Async reset: rst_n pulsed low between clk edges during SETTLE -> outputs 0 before the next edge; a held trigger_turn_right after release -> new right turn with full 4-cycle rotation.

Source files
------------

// File: rtl/turn_executor.sv
// turn_executor: runs one in-place turn (left, right or back) as a timed
// rotation followed by a stationary settle period, then pulses turn_done.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | wheels stopped, triggers sampled while enable is high
//  ROTATE | wheels driven in r_dir for TURN_CYCLES (2x for a back turn)
//  SETTLE | wheels stopped, is_turning held so the detectors refresh
//
// All outputs are registered: the combinational process computes the
// value each output takes in the cycle after the coming edge.
module turn_executor #(
    parameter int TURN_CYCLES   = 450,
    parameter int SETTLE_CYCLES = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic trigger_turn_left,
    input  logic trigger_turn_right,
    input  logic trigger_turn_back,
    output logic is_turning,
    output logic rotate_left,
    output logic rotate_right,
    output logic turn_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Down-counter reload values: the counter is loaded on the edge that
    // enters a state and the state ends on the edge that sees zero, so a
    // reload of N-1 gives exactly N cycles in that state.
    localparam logic [15:0] L_TURN_LOAD   = 16'(TURN_CYCLES - 1);
    localparam logic [15:0] L_BACK_LOAD   = 16'(2 * TURN_CYCLES - 1);
    localparam logic [15:0] L_SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_dir_ccw;
    logic        r_is_turning;
    logic        r_rotate_left;
    logic        r_rotate_right;
    logic        r_turn_done;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_dir_ccw_nxt;
    logic        w_is_turning_nxt;
    logic        w_rotate_left_nxt;
    logic        w_rotate_right_nxt;
    logic        w_turn_done_nxt;
    logic        w_cnt_tc;

    assign w_cnt_tc = (r_cnt == 16'd0);

    // State, counter, direction and output registers; reset aborts any turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= 16'd0;
            r_dir_ccw      <= 1'b0;
            r_is_turning   <= 1'b0;
            r_rotate_left  <= 1'b0;
            r_rotate_right <= 1'b0;
            r_turn_done    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_dir_ccw      <= w_dir_ccw_nxt;
            r_is_turning   <= w_is_turning_nxt;
            r_rotate_left  <= w_rotate_left_nxt;
            r_rotate_right <= w_rotate_right_nxt;
            r_turn_done    <= w_turn_done_nxt;
        end
    end

    // Next state, counter and next-cycle output values.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_dir_ccw_nxt      = r_dir_ccw;
        w_is_turning_nxt   = 1'b0;
        w_rotate_left_nxt  = 1'b0;
        w_rotate_right_nxt = 1'b0;
        w_turn_done_nxt    = 1'b0;

        if (!enable) begin
            // Leaving semi-auto mode drops the turn silently from any state.
            w_state_nxt = IDLE;
            w_cnt_nxt   = 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Back turns reuse the left rotation for twice as long.
                    if (trigger_turn_back) begin
                        w_state_nxt       = ROTATE;
                        w_cnt_nxt         = L_BACK_LOAD;
                        w_dir_ccw_nxt     = 1'b1;
                        w_is_turning_nxt  = 1'b1;
                        w_rotate_left_nxt = 1'b1;
                    end else if (trigger_turn_left) begin
                        w_state_nxt       = ROTATE;
                        w_cnt_nxt         = L_TURN_LOAD;
                        w_dir_ccw_nxt     = 1'b1;
                        w_is_turning_nxt  = 1'b1;
                        w_rotate_left_nxt = 1'b1;
                    end else if (trigger_turn_right) begin
                        w_state_nxt        = ROTATE;
                        w_cnt_nxt          = L_TURN_LOAD;
                        w_dir_ccw_nxt      = 1'b0;
                        w_is_turning_nxt   = 1'b1;
                        w_rotate_right_nxt = 1'b1;
                    end
                end

                ROTATE: begin
                    w_is_turning_nxt = 1'b1;
                    if (w_cnt_tc) begin
                        w_state_nxt = SETTLE;
                        w_cnt_nxt   = L_SETTLE_LOAD;
                    end else begin
                        w_cnt_nxt          = r_cnt - 16'd1;
                        w_rotate_left_nxt  = r_dir_ccw;
                        w_rotate_right_nxt = ~r_dir_ccw;
                    end
                end

                SETTLE: begin
                    if (w_cnt_tc) begin
                        w_state_nxt     = IDLE;
                        w_cnt_nxt       = 16'd0;
                        w_turn_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt        = r_cnt - 16'd1;
                        w_is_turning_nxt = 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    assign is_turning   = r_is_turning;
    assign rotate_left  = r_rotate_left;
    assign rotate_right = r_rotate_right;
    assign turn_done    = r_turn_done;

endmodule

// File: tb/tb_turn_executor.sv
// Bench for turn_executor with TURN_CYCLES=4, SETTLE_CYCLES=2.
// Expected output vectors {is_turning, rotate_left, rotate_right, turn_done}
// are queued when a trigger is driven and compared one per cycle.
module tb_turn_executor;

    localparam int TC = 4;
    localparam int SC = 2;

    localparam logic [3:0] V_IDLE   = 4'b0000;
    localparam logic [3:0] V_ROT_L  = 4'b1100;
    localparam logic [3:0] V_ROT_R  = 4'b1010;
    localparam logic [3:0] V_SETTLE = 4'b1000;
    localparam logic [3:0] V_DONE   = 4'b0001;

    logic clk;
    logic rst_n;
    logic enable;
    logic trigger_turn_left;
    logic trigger_turn_right;
    logic trigger_turn_back;
    logic is_turning;
    logic rotate_left;
    logic rotate_right;
    logic turn_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_cycle  = 0;

    logic [3:0] q_exp[$];

    turn_executor #(
        .TURN_CYCLES  (TC),
        .SETTLE_CYCLES(SC)
    ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .trigger_turn_left (trigger_turn_left),
        .trigger_turn_right(trigger_turn_right),
        .trigger_turn_back (trigger_turn_back),
        .is_turning        (is_turning),
        .rotate_left       (rotate_left),
        .rotate_right      (rotate_right),
        .turn_done         (turn_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {is_turning, rotate_left, rotate_right, turn_done};
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, n_cycle, act, exp);
        end
    endtask

    // One turn's worth of expected cycles, starting with the first
    // rotation cycle after the sampling edge.
    task automatic push_turn(input logic [3:0] rot, input int n_rot);
        for (int i = 0; i < n_rot; i++) q_exp.push_back(rot);
        for (int i = 0; i < SC; i++) q_exp.push_back(V_SETTLE);
        q_exp.push_back(V_DONE);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (q_exp.size() != 0 && budget < 60) begin
            step();
            budget++;
        end
        chk("drain", q_exp.size(), 0);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Scoreboard: an empty queue means the block must be idle.
    always @(negedge clk) begin
        logic [3:0] exp_v;
        n_cycle++;
        if (rst_n) begin
            exp_v = V_IDLE;
            if (q_exp.size() != 0) exp_v = q_exp.pop_front();
            chk("outputs", int'(outs()), int'(exp_v));
            chk("rot_excl", int'(rotate_left & rotate_right), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got timeout expected finish", n_cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        enable             = 1'b0;
        trigger_turn_left  = 1'b0;
        trigger_turn_right = 1'b0;
        trigger_turn_back  = 1'b0;
        #3;
        chk("reset_outs", int'(outs()), int'(V_IDLE));
        step();
        step();
        rst_n = 1'b1;
        step();
        enable = 1'b1;
        idle_steps(2);

        // Single-cycle left pulse.
        trigger_turn_left = 1'b1;
        push_turn(V_ROT_L, TC);
        step();
        trigger_turn_left = 1'b0;
        wait_drain();
        idle_steps(3);

        // Back turn: double-length left rotation.
        trigger_turn_back = 1'b1;
        push_turn(V_ROT_L, 2 * TC);
        step();
        trigger_turn_back = 1'b0;
        wait_drain();
        idle_steps(2);

        // All three at once: back wins.
        trigger_turn_back  = 1'b1;
        trigger_turn_left  = 1'b1;
        trigger_turn_right = 1'b1;
        push_turn(V_ROT_L, 2 * TC);
        step();
        trigger_turn_back  = 1'b0;
        trigger_turn_left  = 1'b0;
        trigger_turn_right = 1'b0;
        wait_drain();
        idle_steps(2);

        // Left + right: left wins; a right pulse mid-rotation is dropped.
        trigger_turn_left  = 1'b1;
        trigger_turn_right = 1'b1;
        push_turn(V_ROT_L, TC);
        step();
        trigger_turn_left  = 1'b0;
        trigger_turn_right = 1'b0;
        step();
        trigger_turn_right = 1'b1;
        step();
        trigger_turn_right = 1'b0;
        wait_drain();
        idle_steps(4);

        // Plain right turn.
        trigger_turn_right = 1'b1;
        push_turn(V_ROT_R, TC);
        step();
        trigger_turn_right = 1'b0;
        wait_drain();
        idle_steps(2);

        // Held left trigger restarts on the first idle edge after turn_done.
        trigger_turn_left = 1'b1;
        push_turn(V_ROT_L, TC);
        push_turn(V_ROT_L, TC);
        idle_steps(8);
        trigger_turn_left = 1'b0;
        wait_drain();
        idle_steps(3);

        // Enable dropped on the 2nd rotation cycle.
        trigger_turn_left = 1'b1;
        push_turn(V_ROT_L, TC);
        step();
        trigger_turn_left = 1'b0;
        step();
        enable = 1'b0;
        q_exp.delete();
        step();
        trigger_turn_left = 1'b1;
        idle_steps(3);
        trigger_turn_back = 1'b1;
        idle_steps(2);
        trigger_turn_left = 1'b0;
        trigger_turn_back = 1'b0;
        step();
        enable = 1'b1;
        idle_steps(10);

        // Async reset during SETTLE, then a held right trigger.
        trigger_turn_right = 1'b1;
        push_turn(V_ROT_R, TC);
        step();
        trigger_turn_right = 1'b0;
        idle_steps(TC);
        chk("pre_rst_settle", int'(outs()), int'(V_SETTLE));
        rst_n = 1'b0;
        q_exp.delete();
        #1;
        chk("async_rst", int'(outs()), int'(V_IDLE));
        trigger_turn_right = 1'b1;
        #1;
        rst_n = 1'b1;
        push_turn(V_ROT_R, TC);
        step();
        trigger_turn_right = 1'b0;
        wait_drain();
        idle_steps(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
